// File: rtl/osb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osb_pkg
// Description : Shared types and constants for the Osborne main-RAM arbiter.
//               Holds the arbiter state encoding, the grant encoding, the
//               default address/data widths and the eligibility bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package osb_pkg;

  localparam int OSB_ADDR_W = 16;
  localparam int OSB_DATA_W = 8;

  // Bit positions inside the eligibility vector handed to the grant picker
  localparam int ELIG_VID = 0;
  localparam int ELIG_IO  = 1;
  localparam int ELIG_CPU = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_IO   = 2'd2,
    GNT_CPU  = 2'd3
  } grant_t;

  // Width of a saturating counter that must be able to hold max_skip
  function automatic int skip_cnt_w(input int max_skip);
    if (max_skip < 2) return 1;
    return $clog2(max_skip + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/osb_grant_pick.sv
`default_nettype none
// ============================================================================
// Module      : osb_grant_pick
// Description : Combinational grant selection. Fixed priority vid > io > cpu,
//               overridden in favour of the CPU once the skip counter has
//               reached CPU_MAX_SKIP.
// Ports       : elig_i     - {cpu, io, vid} eligibility (req & ~ack)
//               skip_cnt_i - consecutive non-CPU grants while CPU pending
//               grant_o    - selected requester (GNT_NONE if nobody eligible)
// Revision    : 1.0 - initial release
// ============================================================================
module osb_grant_pick
  import osb_pkg::*;
#(
  parameter int CPU_MAX_SKIP = 2,
  parameter int SKIP_W       = skip_cnt_w(CPU_MAX_SKIP)
) (
  input  logic [2:0]        elig_i,
  input  logic [SKIP_W-1:0] skip_cnt_i,
  output grant_t            grant_o
);

  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(CPU_MAX_SKIP);

  always_comb begin
    grant_o = GNT_NONE;
    if (elig_i[ELIG_CPU] && (skip_cnt_i == SKIP_MAX)) begin
      grant_o = GNT_CPU;
    end else if (elig_i[ELIG_VID]) begin
      grant_o = GNT_VID;
    end else if (elig_i[ELIG_IO]) begin
      grant_o = GNT_IO;
    end else if (elig_i[ELIG_CPU]) begin
      grant_o = GNT_CPU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/osb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : osb_ram_arbiter
// Description : Shares the single-port 64 KiB main RAM between video fetch,
//               HPS ioctl download and the Z80. One access at a time is run
//               through IDLE -> ISSUE -> CAPTURE; completion is a one-cycle
//               ack per requester, with read data held until the next read.
// Ports       : clk_sys/reset_n        - clock, async active-low reset
//               vid_*                  - read-only video requester
//               io_*                   - write-only ioctl requester
//               cpu_*                  - read/write CPU requester
//               ram_*                  - registered RAM macro interface
//               busy                   - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module osb_ram_arbiter
  import osb_pkg::*;
#(
  parameter int ADDR_W       = OSB_ADDR_W,
  parameter int DATA_W       = OSB_DATA_W,
  parameter int CPU_MAX_SKIP = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ack,
  input  logic              io_req,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int                SKIP_W   = skip_cnt_w(CPU_MAX_SKIP);
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(CPU_MAX_SKIP);
  localparam logic [SKIP_W-1:0] SKIP_ONE = SKIP_W'(1);

  state_t              state_q,     state_d;
  grant_t              grant_q,     grant_d;
  logic                op_we_q,     op_we_d;
  logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
  logic                ram_we_q,    ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                vid_ack_q,   vid_ack_d;
  logic                io_ack_q,    io_ack_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic [SKIP_W-1:0]   skip_cnt_q,  skip_cnt_d;

  logic [2:0]          elig;
  grant_t              pick;

  // A requester still showing its ack is dropping req; never regrant it.
  assign elig[ELIG_VID] = vid_req & ~vid_ack_q;
  assign elig[ELIG_IO]  = io_req  & ~io_ack_q;
  assign elig[ELIG_CPU] = cpu_req & ~cpu_ack_q;

  osb_grant_pick #(
    .CPU_MAX_SKIP (CPU_MAX_SKIP),
    .SKIP_W       (SKIP_W)
  ) u_grant_pick (
    .elig_i     (elig),
    .skip_cnt_i (skip_cnt_q),
    .grant_o    (pick)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      op_we_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      vid_ack_q   <= 1'b0;
      io_ack_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      skip_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_we_q     <= op_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_ack_q   <= vid_ack_d;
      io_ack_q    <= io_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      skip_cnt_q  <= skip_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    op_we_d     = op_we_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_ack_d   = 1'b0;
    io_ack_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    skip_cnt_d  = skip_cnt_q;

    case (state_q)
      IDLE: begin
        if (!cpu_req) begin
          skip_cnt_d = '0;
        end
        if (pick != GNT_NONE) begin
          grant_d = pick;
          state_d = ISSUE;
        end
        case (pick)
          GNT_VID: begin
            ram_addr_d  = vid_addr;
            ram_we_d    = 1'b0;
            ram_wdata_d = '0;
            op_we_d     = 1'b0;
          end
          GNT_IO: begin
            ram_addr_d  = io_addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = io_wdata;
            op_we_d     = 1'b1;
          end
          GNT_CPU: begin
            ram_addr_d  = cpu_addr;
            ram_we_d    = cpu_we;
            ram_wdata_d = cpu_wdata;
            op_we_d     = cpu_we;
            skip_cnt_d  = '0;
          end
          default: ;
        endcase
        // Count a pass-over only when the CPU is actually waiting.
        if (((pick == GNT_VID) || (pick == GNT_IO)) && cpu_req &&
            (skip_cnt_q != SKIP_MAX)) begin
          skip_cnt_d = skip_cnt_q + SKIP_ONE;
        end
      end

      ISSUE: begin
        ram_we_d = 1'b0;
        state_d  = CAPTURE;
      end

      CAPTURE: begin
        case (grant_q)
          GNT_VID: begin
            vid_rdata_d = ram_rdata;
            vid_ack_d   = 1'b1;
          end
          GNT_IO: begin
            io_ack_d = 1'b1;
          end
          GNT_CPU: begin
            if (!op_we_q) begin
              cpu_rdata_d = ram_rdata;
            end
            cpu_ack_d = 1'b1;
          end
          default: ;
        endcase
        grant_d = GNT_NONE;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign vid_rdata = vid_rdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign io_ack    = io_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_osb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_osb_ram_arbiter
// Description : Self-checking bench for osb_ram_arbiter with a behavioural
//               synchronous RAM, directed scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osb_ram_arbiter;

  localparam int MAXSKIP = 2;

  logic        clk_sys;
  logic        reset_n;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_ack;
  logic        io_req;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic        io_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // RAM model plus a preload port owned by the stimulus process
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  mem [0:65535];

  logic [7:0]  cpu_shadow [0:255];
  logic [7:0]  io_shadow  [0:255];
  bit          io_valid   [0:255];

  osb_ram_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (8),
    .CPU_MAX_SKIP (MAXSKIP)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_rdata (vid_rdata),
    .vid_ack   (vid_ack),
    .io_req    (io_req),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_ack    (io_ack),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [7:0] pat_vid(input logic [15:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  function automatic logic [7:0] pat_cpu(input logic [15:0] a);
    return a[7:0] + 8'h11;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      pre_we   = 1'b1;
      pre_addr = 16'(i);
      pre_data = pat_vid(16'(i));
      tick();
      pre_addr      = 16'h4000 | 16'(i);
      pre_data      = pat_cpu(16'h4000 | 16'(i));
      cpu_shadow[i] = pre_data;
      tick();
    end
    pre_addr = 16'h1234;
    pre_data = 8'hA5;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    io_req = 1'b0; io_addr = '0; io_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    preload();
    checks++;
    if ({ram_addr, ram_we, ram_wdata, vid_rdata, cpu_rdata, vid_ack, io_ack, cpu_ack, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr=%h we=%b wdata=%h vrd=%h crd=%h acks=%b%b%b busy=%b, required all zero",
               ram_addr, ram_we, ram_wdata, vid_rdata, cpu_rdata, vid_ack, io_ack, cpu_ack, busy);
    end
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b required 0", busy);
    end
  endtask

  task automatic test_cpu_read();
    cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00; cpu_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (ram_addr !== 16'h1234 || ram_we !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL cpu_read_issue: addr=%h we=%b busy=%b required 1234/0/1", ram_addr, ram_we, busy);
        end
      end
      checks++;
      if ({vid_ack, io_ack, cpu_ack} !== {2'b00, (c == 3)}) begin
        errors++;
        $display("FAIL cpu_read_ack c%0d: acks=%b%b%b required 00%0d", c, vid_ack, io_ack, cpu_ack, (c == 3));
      end
      if (c == 3 || c == 5) begin
        checks++;
        if (cpu_rdata !== 8'hA5) begin
          errors++;
          $display("FAIL cpu_read_data c%0d: got %h required a5", c, cpu_rdata);
        end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    int we_cnt = 0;
    io_addr = 16'hF000; io_wdata = 8'h3C; io_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (ram_we) we_cnt++;
      if (c == 1) begin
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 16'hF000 || ram_wdata !== 8'h3C) begin
          errors++;
          $display("FAIL io_write_issue: we=%b addr=%h wdata=%h required 1/f000/3c", ram_we, ram_addr, ram_wdata);
        end
      end
      checks++;
      if (io_ack !== (c == 3)) begin
        errors++;
        $display("FAIL io_write_ack c%0d: got %b required %0d", c, io_ack, (c == 3));
      end
      if (c == 3) io_req = 1'b0;
    end
    checks++;
    if (we_cnt != 1 || mem[16'hF000] !== 8'h3C || cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL io_write_effect: we_cycles=%0d mem=%h cpu_rdata=%h required 1/3c/a5",
               we_cnt, mem[16'hF000], cpu_rdata);
    end
    cpu_we = 1'b0; cpu_addr = 16'hF000; cpu_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (cpu_ack !== (c == 3)) begin
        errors++;
        $display("FAIL readback_ack c%0d: got %b required %0d", c, cpu_ack, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (cpu_rdata !== 8'h3C) begin
          errors++;
          $display("FAIL readback_data: got %h required 3c", cpu_rdata);
        end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous();
    int vc = -1, ic = -1, cc = -1, acks = 0;
    vid_addr = 16'h0010;
    io_addr = 16'h8001; io_wdata = 8'h77;
    cpu_we = 1'b0; cpu_addr = 16'h4005;
    vid_req = 1'b1; io_req = 1'b1; cpu_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      acks += int'(vid_ack) + int'(io_ack) + int'(cpu_ack);
      if (vid_ack) begin vc = c; vid_req = 1'b0; end
      if (io_ack)  begin ic = c; io_req  = 1'b0; end
      if (cpu_ack) begin cc = c; cpu_req = 1'b0; end
    end
    checks++;
    if (vc != 3 || ic != 6 || cc != 9 || acks != 3) begin
      errors++;
      $display("FAIL simult_order: ack cycles vid=%0d io=%0d cpu=%0d total=%0d required 3/6/9 total 3",
               vc, ic, cc, acks);
    end
    checks++;
    if (vid_rdata !== pat_vid(16'h0010) || cpu_rdata !== cpu_shadow[5] || mem[16'h8001] !== 8'h77) begin
      errors++;
      $display("FAIL simult_data: vid=%h cpu=%h mem=%h required %h/%h/77",
               vid_rdata, cpu_rdata, mem[16'h8001], pat_vid(16'h0010), cpu_shadow[5]);
    end
  endtask

  // vid and io both keep requesting while the CPU waits: the CPU must win
  // after exactly MAXSKIP non-CPU grants, giving vid, io, cpu repeating.
  task automatic test_starvation();
    int stray = 0;
    logic [2:0] exp;
    vid_addr = 16'h0020;
    io_addr = 16'h8002; io_wdata = 8'h99;
    cpu_we = 1'b0; cpu_addr = 16'h4007;
    vid_req = 1'b1; io_req = 1'b1; cpu_req = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (c % 3 == 0) begin
        case ((c / 3) % 3)
          1:       exp = 3'b100;
          2:       exp = 3'b010;
          default: exp = 3'b001;
        endcase
        checks++;
        if ({vid_ack, io_ack, cpu_ack} !== exp) begin
          errors++;
          $display("FAIL starve_order c%0d: acks(vid,io,cpu)=%b required %b", c, {vid_ack, io_ack, cpu_ack}, exp);
        end
        if (cpu_ack && cpu_rdata !== cpu_shadow[7]) begin
          errors++;
          $display("FAIL starve_cpu_data c%0d: got %h required %h", c, cpu_rdata, cpu_shadow[7]);
        end
      end else if (vid_ack | io_ack | cpu_ack) begin
        stray++;
      end
    end
    vid_req = 1'b0; io_req = 1'b0; cpu_req = 1'b0;
    repeat (4) tick();
    checks++;
    if (stray != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_tail: stray acks=%0d busy=%b required 0/0", stray, busy);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    vid_addr = 16'h0030; vid_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (vid_ack) begin
        acks++;
        checks++;
        if (vid_rdata !== pat_vid(16'h0030)) begin
          errors++;
          $display("FAIL b2b_data: got %h required %h", vid_rdata, pat_vid(16'h0030));
        end
      end
      if (c == 4) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stale_grant: busy=%b after ack cycle required 0", busy);
        end
        vid_req = 1'b0;
      end
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL b2b_ack_count: got %0d required 1", acks);
    end
  endtask

  task automatic test_reset_midop();
    int ack_seen = 0;
    cpu_we = 1'b1; cpu_addr = 16'h4010; cpu_wdata = 8'hEE; cpu_req = 1'b1;
    tick();
    checks++;
    if (ram_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_issue: we=%b busy=%b required 1/1", ram_we, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ram_addr, ram_we, ram_wdata, vid_rdata, cpu_rdata, vid_ack, io_ack, cpu_ack, busy} !== '0) begin
      errors++;
      $display("FAIL midop_async_reset: addr=%h we=%b wdata=%h acks=%b%b%b busy=%b required all zero",
               ram_addr, ram_we, ram_wdata, vid_ack, io_ack, cpu_ack, busy);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (cpu_ack) ack_seen++;
    end
    checks++;
    if (ack_seen != 0 || mem[16'h4010] !== cpu_shadow[16]) begin
      errors++;
      $display("FAIL midop_abandon: acks=%0d mem=%h required 0/%h", ack_seen, mem[16'h4010], cpu_shadow[16]);
    end
    reset_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (cpu_ack !== (c == 3)) begin
        errors++;
        $display("FAIL midop_reissue_ack c%0d: got %b required %0d", c, cpu_ack, (c == 3));
      end
      if (c == 3) cpu_req = 1'b0;
    end
    cpu_shadow[16] = 8'hEE;
    checks++;
    if (mem[16'h4010] !== 8'hEE || cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL midop_reissue_effect: mem=%h cpu_rdata=%h required ee/00", mem[16'h4010], cpu_rdata);
    end
  endtask

  task automatic test_random();
    bit vid_done = 0, io_done = 0, cpu_done = 0;
    int mem_bad = 0;
    for (int i = 0; i < 256; i++) io_valid[i] = 1'b0;
    fork
      begin : p_vid
        for (int t = 0; t < 25; t++) begin
          logic [31:0] r;
          logic [15:0] a;
          bit got;
          r = $urandom();
          repeat (int'(r[9:8])) tick();
          a = {8'h00, r[7:0]};
          vid_addr = a; vid_req = 1'b1; got = 0;
          for (int w = 0; w < 40 && !got; w++) begin tick(); if (vid_ack) got = 1; end
          checks++;
          if (!got) begin
            errors++;
            $display("FAIL rand_vid_timeout: no ack in 40 cycles addr=%h", a);
          end else if (vid_rdata !== pat_vid(a)) begin
            errors++;
            $display("FAIL rand_vid_data: addr=%h got %h required %h", a, vid_rdata, pat_vid(a));
          end
          vid_req = 1'b0;
        end
        vid_done = 1;
      end
      begin : p_io
        for (int t = 0; t < 20; t++) begin
          logic [31:0] r;
          bit got;
          r = $urandom();
          repeat (int'(r[17:16])) tick();
          io_addr = {8'h80, r[7:0]}; io_wdata = r[15:8]; io_req = 1'b1; got = 0;
          for (int w = 0; w < 40 && !got; w++) begin tick(); if (io_ack) got = 1; end
          checks++;
          if (!got) begin
            errors++;
            $display("FAIL rand_io_timeout: no ack in 40 cycles addr=%h", io_addr);
          end
          io_shadow[r[7:0]] = r[15:8];
          io_valid[r[7:0]]  = 1'b1;
          io_req = 1'b0;
        end
        io_done = 1;
      end
      begin : p_cpu
        for (int t = 0; t < 25; t++) begin
          logic [31:0] r;
          logic [7:0] exp;
          bit got;
          r = $urandom();
          repeat (int'(r[25:24])) tick();
          cpu_addr = {8'h40, r[7:0]}; cpu_we = r[16]; cpu_wdata = r[15:8];
          exp = cpu_shadow[r[7:0]];
          if (r[16]) cpu_shadow[r[7:0]] = r[15:8];
          cpu_req = 1'b1; got = 0;
          for (int w = 0; w < 40 && !got; w++) begin tick(); if (cpu_ack) got = 1; end
          checks++;
          if (!got) begin
            errors++;
            $display("FAIL rand_cpu_timeout: no ack in 40 cycles addr=%h", cpu_addr);
          end else if (!r[16] && cpu_rdata !== exp) begin
            errors++;
            $display("FAIL rand_cpu_data: addr=%h got %h required %h", cpu_addr, cpu_rdata, exp);
          end
          cpu_req = 1'b0;
        end
        cpu_done = 1;
      end
      begin : p_mon
        int pend = 0;
        for (int cyc = 0; cyc < 6000 && !(vid_done && io_done && cpu_done); cyc++) begin
          @(negedge clk_sys);
          if (vid_ack | io_ack | cpu_ack) begin
            checks++;
            if ($countones({vid_ack, io_ack, cpu_ack}) > 1) begin
              errors++;
              $display("FAIL rand_ack_onehot: acks=%b%b%b required at most one", vid_ack, io_ack, cpu_ack);
            end
          end
          if (cpu_ack || !cpu_req) begin
            pend = 0;
          end else if (vid_ack || io_ack) begin
            // one grant made before the CPU asked may still complete
            pend++;
            checks++;
            if (pend > MAXSKIP + 1) begin
              errors++;
              $display("FAIL rand_starvation: %0d non-cpu acks while cpu waits, limit %0d", pend, MAXSKIP + 1);
            end
          end
        end
      end
    join
    repeat (4) tick();
    for (int i = 0; i < 256; i++) begin
      if (io_valid[i] && mem[16'h8000 | 16'(i)] !== io_shadow[i]) mem_bad++;
      if (mem[16'h4000 | 16'(i)] !== cpu_shadow[i]) mem_bad++;
    end
    checks++;
    if (mem_bad != 0) begin
      errors++;
      $display("FAIL rand_mem_contents: %0d bytes differ, required 0", mem_bad);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_read();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
